fsquare: RTL and testbench

Pipelined single-precision floating-point squarer, `y = x*x`, the inverse companion to the FPU's square-root unit. It sits in the FPU execute cluster beside `fsqrt` and is used for reciprocal-sqrt refinement and for the `fsqr` instruction. It takes one operand per cycle through a valid/ready handshake and returns results in order after a fixed three-stage pipeline. Round-to-nearest-even; subnormals flushed to zero.

---
 rtl/fsquare.sv | 149 ++++++++++++++
 tb/tb_fsquare.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fsquare.sv
// Pipelined single-precision squarer y = x*x: round-to-nearest-even, flush-to-zero.
// Three stages (partial products / sum+normalise / round+pack) under one global advance enable.
module fsquare (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y
);

   typedef enum logic [1:0] {
      CL_NORM,
      CL_ZERO,
      CL_INF,
      CL_NAN
   } cls_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [31:0] PINF = 32'h7F80_0000;

   logic adv;
   logic v1, v2, v3;

   assign adv       = !v3 | out_ready;
   assign in_ready  = adv;
   assign out_valid = v3;

   // A square is never negative, so the operand sign plays no part.
   logic sign_unused;
   assign sign_unused = x[31];

   // ---------------- stage 1: classify and form partial products ----------------
   logic [7:0]  e_in;
   logic [23:0] m_in;
   cls_t        cls_d;
   logic [35:0] pp_lo_d, pp_hi_d;

   assign e_in    = x[30:23];
   assign m_in    = {1'b1, x[22:0]};
   assign pp_lo_d = {12'd0, m_in} * {24'd0, m_in[11:0]};
   assign pp_hi_d = {12'd0, m_in} * {24'd0, m_in[23:12]};

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      cls_d = CL_NORM;
      if (e_in == 8'hFF)
         cls_d = (x[22:0] != 23'd0) ? CL_NAN : CL_INF;
      else if (e_in == 8'h00)
         cls_d = CL_ZERO;
   end

   cls_t        cls1;
   logic [7:0]  e1;
   logic [35:0] pp_lo1, pp_hi1;

   // ---------------- stage 2: sum, normalise, extract guard/sticky ----------------
   logic [47:0]       p;
   logic [22:0]       mant_d;
   logic              guard_d, sticky_d;
   logic signed [9:0] ex_d;
   logic signed [9:0] ex_base;

   assign p       = {12'd0, pp_lo1} + {pp_hi1, 12'd0};
   assign ex_base = $signed({1'b0, e1, 1'b0});

   always_comb begin
      mant_d   = p[45:23];
      guard_d  = p[22];
      sticky_d = |p[21:0];
      ex_d     = ex_base - 10'sd127;
      if (p[47]) begin
         mant_d   = p[46:24];
         guard_d  = p[23];
         sticky_d = |p[22:0];
         ex_d     = ex_base - 10'sd126;
      end
   end

   cls_t              cls2;
   logic [22:0]       mant2;
   logic              guard2, sticky2;
   logic signed [9:0] ex2;

   // ---------------- stage 3: round, range-check, pack ----------------
   logic              round_up;
   logic [23:0]       mant_r;
   logic signed [9:0] ex_r;
   logic [31:0]       y_d;

   assign round_up = guard2 & (sticky2 | mant2[0]);
   assign mant_r   = {1'b0, mant2} + {23'd0, round_up};
   // A carry out of the mantissa leaves 1.000..0, i.e. one exponent step up.
   assign ex_r     = ex2 + (mant_r[23] ? 10'sd1 : 10'sd0);

   always_comb begin
      y_d = 32'd0;
      unique case (cls2)
         CL_NAN:  y_d = QNAN;
         CL_INF:  y_d = PINF;
         CL_ZERO: y_d = 32'd0;
         default: begin
            if (ex_r >= 10'sd255)
               y_d = PINF;
            else if (ex_r <= 10'sd0)
               y_d = 32'd0;
            else
               y_d = {1'b0, ex_r[7:0], (mant_r[23] ? 23'd0 : mant_r[22:0])};
         end
      endcase
   end

   // ---------------- registers ----------------
   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         y  <= 32'd0;
      end else if (adv) begin
         v1 <= in_valid;
         v2 <= v1;
         v3 <= v2;
         if (v2)
            y <= y_d;
      end
   end

   // NOTE: datapath registers are deliberately left without reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (adv && in_valid) begin
         cls1   <= cls_d;
         e1     <= e_in;
         pp_lo1 <= pp_lo_d;
         pp_hi1 <= pp_hi_d;
      end
      if (adv && v1) begin
         cls2    <= cls1;
         mant2   <= mant_d;
         guard2  <= guard_d;
         sticky2 <= sticky_d;
         ex2     <= ex_d;
      end
   end

endmodule

// File: tb/tb_fsquare.sv
// Directed bench for fsquare: hand-computed vectors, stall/hold, mid-stream reset,
// plus a short randomised run scored against an independent RNE/FTZ model.
module tb_fsquare;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] x = 32'd0;
   logic        in_ready, out_valid;
   logic [31:0] y;

   fsquare dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] y;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          chk_lat = 1'b0;
   bit          hold_pending = 1'b0;
   logic [31:0] held_y = 32'd0;

   logic [31:0] dir_x [16] = '{
      32'h4000_0000, 32'h3FC0_0000, 32'hC040_0000, 32'h3F80_0001,
      32'h3F80_0800, 32'h3F80_0801, 32'h3FB5_04F3, 32'h3FFF_FFFF,
      32'h5F80_0000, 32'h5F7F_FFFF, 32'h2000_0000, 32'h1F80_0000,
      32'h1FFF_FFFF, 32'h0040_0000, 32'hFF80_0000, 32'h7FA0_0001};
   logic [31:0] dir_y [16] = '{
      32'h4080_0000, 32'h4010_0000, 32'h4110_0000, 32'h3F80_0002,
      32'h3F80_1000, 32'h3F80_1003, 32'h3FFF_FFFF, 32'h407F_FFFE,
      32'h7F80_0000, 32'h7F7F_FFFE, 32'h0080_0000, 32'h0000_0000,
      32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_sq(input logic [31:0] a);
      logic [7:0]  e;
      logic [22:0] f;
      logic [47:0] p;
      logic [23:0] mt;
      logic        g, st;
      int          ex;
      e = a[30:23];
      f = a[22:0];
      if (e == 8'hFF) return (f != 23'd0) ? 32'h7FC0_0000 : 32'h7F80_0000;
      if (e == 8'h00) return 32'd0;
      p = {24'd0, 1'b1, f} * {24'd0, 1'b1, f};
      if (p[47]) begin
         mt = {1'b0, p[46:24]}; g = p[23]; st = |p[22:0]; ex = 2 * int'(e) - 126;
      end else begin
         mt = {1'b0, p[45:23]}; g = p[22]; st = |p[21:0]; ex = 2 * int'(e) - 127;
      end
      if (g && (st || mt[0])) mt = mt + 24'd1;
      if (mt[23]) begin
         ex = ex + 1;
         mt = 24'd0;
      end
      if (ex >= 255) return 32'h7F80_0000;
      if (ex <= 0) return 32'd0;
      return {1'b0, 8'(ex), mt[22:0]};
   endfunction

   // One clock cycle: drive after the falling edge, observe 1 time unit later.
   task automatic step(input logic v, input logic [31:0] xv, input logic [31:0] ev,
                       input logic ordy, output bit fired);
      exp_t ent;
      @(negedge clk);
      in_valid  = v;
      x         = xv;
      out_ready = ordy;
      #1;
      if (hold_pending) begin
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_y", y, held_y);
      end
      hold_pending = out_valid & !out_ready;
      held_y       = y;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_out", y, 32'hDEAD_BEEF);
         end else begin
            ent = sb.pop_front();
            check("result", y, ent.y);
            if (chk_lat) check("latency", 32'(cyc - ent.cyc), 32'd3);
         end
      end
      fired = in_valid && in_ready;
      if (fired) sb.push_back('{ev, cyc});
      cyc++;
   endtask

   task automatic drain(input string tag);
      bit f;
      for (int k = 0; k < 50 && sb.size() > 0; k++) step(1'b0, 32'd0, 32'd0, 1'b1, f);
      for (int k = 0; k < 4; k++) step(1'b0, 32'd0, 32'd0, 1'b1, f);
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   function automatic logic [31:0] gen_operand();
      logic [31:0] r;
      logic [7:0]  eb;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: r[30:23] = 8'hFF;
         1: r[30:23] = 8'h00;
         2: begin
            case ($urandom_range(0, 3))
               0: eb = 8'd63;
               1: eb = 8'd64;
               2: eb = 8'd190;
               default: eb = 8'd191;
            endcase
            r[30:23] = eb;
         end
         3: r[22:0] = ($urandom_range(0, 1) != 0) ? 23'd0 : 23'h7F_FFFF;
         default: ;
      endcase
      return r;
   endfunction

   initial begin
      bit f;
      int i, sent;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_y", y, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rstn = 1'b1;

      // Back-to-back directed vectors, latency 3, one per cycle
      chk_lat = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step(1'b1, dir_x[k], dir_y[k], 1'b1, f);
         check("dir_accept", {31'd0, f}, 32'd1);
      end
      drain("dir_drain");

      // Backpressure: out_ready low for 5 cycles once the first result is present
      chk_lat = 1'b0;
      i = 0;
      for (int t = 0; t < 60 && (i < 6 || sb.size() > 0); t++) begin
         step(i < 6, dir_x[i % 6], dir_y[i % 6], !(t >= 3 && t < 8), f);
         if (t >= 3 && t < 8) begin
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
         end
         if (f) i++;
      end
      check("bp_sent", 32'(i), 32'd6);
      drain("bp_drain");

      // Asynchronous reset with all three stages occupied
      chk_lat = 1'b1;
      for (int k = 0; k < 3; k++) step(1'b1, dir_x[k], dir_y[k], 1'b1, f);
      @(negedge clk);
      rstn     = 1'b0;
      in_valid = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_y", y, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      sb.delete();
      hold_pending = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      step(1'b1, 32'h4040_0000, 32'h4110_0000, 1'b1, f);
      check("postrst_accept", {31'd0, f}, 32'd1);
      drain("postrst_drain");

      // Randomised traffic against the reference model
      chk_lat = 1'b0;
      sent = 0;
      for (int k = 0; k < 20000 && sent < 3000; k++) begin
         logic [31:0] xv;
         xv = gen_operand();
         step($urandom_range(0, 3) != 0, xv, ref_sq(xv), $urandom_range(0, 3) != 0, f);
         if (f) sent++;
      end
      check("rand_sent", 32'(sent), 32'd3000);
      drain("rand_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
